mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port unified memory of the multicycle CPU. Port 0 is the CPU controller's instruction-fetch and load/store access. Port 1 is a secondary master, such as the program loader or debug port. The block serialises both ports onto one registered memory request with a ready handshake, alternates priority round-robin when both ports contend, and gives the CPU a stall signal so its state machine holds in fetch and memory states until the access completes.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port unified memory between the CPU controller (port 0)
// and a secondary master such as the loader or debug port (port 1).
// One access is in flight at a time. The memory request is registered, ties
// are broken round-robin, and a watchdog aborts accesses the memory never
// completes. stall0 holds the CPU state machine until its access finishes.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic          err0,
   output logic          err1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          stall0,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BUSY0 = 2'd1;
   localparam logic [1:0] BUSY1 = 2'd2;

   // The wait counter only has to reach TIMEOUT-1, so it is sized for that.
   localparam int            CW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST_CNT    = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit            WATCHDOG_ON = (TIMEOUT != 0);

   logic [1:0]    state;
   logic          prio;
   logic [CW-1:0] waitCnt;

   logic cand0;
   logic cand1;
   logic grant0;
   logic grant1;
   logic busy;
   logic busyPort;
   logic finish;
   logic timedOut;

   // Pick the port to serve from IDLE; a port being acked or aborted this cycle
   // is not yet eligible, which keeps one idle memory cycle between accesses.
   always_comb begin
      cand0  = req0 & ~ack0 & ~err0;
      cand1  = req1 & ~ack1 & ~err1;
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
         grant0 = cand0 & (~cand1 | ~prio);
         grant1 = cand1 & (~cand0 | prio);
      end
   end

   // Decide whether the access in flight ends this cycle; memory completion
   // beats the watchdog when both happen together, and mem_ready is ignored in IDLE.
   always_comb begin
      busy     = (state == BUSY0) || (state == BUSY1);
      busyPort = (state == BUSY1);
      finish   = busy & mem_ready;
      timedOut = busy & ~mem_ready & WATCHDOG_ON & (waitCnt == LAST_CNT);
   end

   // Track the owner of the memory, the round-robin tie-break and the wait time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         prio    <= 1'b0;
         waitCnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0) begin
                  state   <= BUSY0;
                  waitCnt <= '0;
               end else if (grant1) begin
                  state   <= BUSY1;
                  waitCnt <= '0;
               end
            end
            BUSY0, BUSY1: begin
               if (finish || timedOut) begin
                  state <= IDLE;
                  prio  <= ~busyPort;
               end else begin
                  waitCnt <= waitCnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Capture the winner's access at grant time and hold it until completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (grant0) begin
         mem_req   <= 1'b1;
         mem_we    <= we0;
         mem_addr  <= addr0;
         mem_wdata <= wdata0;
      end else if (grant1) begin
         mem_req   <= 1'b1;
         mem_we    <= we1;
         mem_addr  <= addr1;
         mem_wdata <= wdata1;
      end else if (finish || timedOut) begin
         mem_req   <= 1'b0;
      end
   end

   // Return one-cycle completion/abort pulses and keep the last read data per port.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         err0   <= 1'b0;
         err1   <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         ack0 <= finish & ~busyPort;
         ack1 <= finish & busyPort;
         err0 <= timedOut & ~busyPort;
         err1 <= timedOut & busyPort;
         if (finish && !mem_we && !busyPort) begin
            rdata0 <= mem_rdata;
         end
         if (finish && !mem_we && busyPort) begin
            rdata1 <= mem_rdata;
         end
      end
   end

   // The CPU waits while its request is outstanding and not yet answered.
   assign stall0 = req0 & ~ack0 & ~err0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Bench for mem_port_arbiter: a table of directed cycles, hand-written corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int MAIN_TIMEOUT = 8;

   logic        clk;
   logic        rst;

   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        memReady;
   logic [31:0] memRdata;
   logic        ack0, ack1, err0, err1, stall0;
   logic [31:0] rdata0, rdata1;
   logic        memReq, memWe;
   logic [31:0] memAddr, memWdata;

   logic        req0T, we0T, req1T, we1T;
   logic [31:0] addr0T, wdata0T, addr1T, wdata1T;
   logic        memReadyT;
   logic [31:0] memRdataT;
   logic        ack0T, ack1T, err0T, err1T, stall0T;
   logic [31:0] rdata0T, rdata1T;
   logic        memReqT, memWeT;
   logic [31:0] memAddrT, memWdataT;

   int compared;
   int mismatched;

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(MAIN_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata0(rdata0), .rdata1(rdata1), .stall0(stall0),
      .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .mem_ready(memReady)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dutT4 (
      .clk(clk), .rst(rst),
      .req0(req0T), .we0(we0T), .addr0(addr0T), .wdata0(wdata0T),
      .req1(req1T), .we1(we1T), .addr1(addr1T), .wdata1(wdata1T),
      .ack0(ack0T), .ack1(ack1T), .err0(err0T), .err1(err1T),
      .rdata0(rdata0T), .rdata1(rdata1T), .stall0(stall0T),
      .mem_req(memReqT), .mem_we(memWeT), .mem_addr(memAddrT), .mem_wdata(memWdataT),
      .mem_rdata(memRdataT), .mem_ready(memReadyT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        r0;
      logic        w0;
      logic [31:0] a0;
      logic [31:0] d0;
      logic        r1;
      logic        w1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic        rdy;
      logic [31:0] mrd;
      logic        eStall0;
      logic        eAck0;
      logic        eAck1;
      logic        eErr0;
      logic        eErr1;
      logic        eMemReq;
      logic        eMemValid;
      logic        eMemWe;
      logic [31:0] eMemAddr;
      logic [31:0] eMemWdata;
      logic [31:0] eRd0;
      logic [31:0] eRd1;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   // Reference model state: who owns the memory and for how many cycles.
   int          mOwner;
   int          mAge;
   int          mPrio;
   bit          mMemReq;
   bit          mLatWe;
   logic [31:0] mLatAddr;
   logic [31:0] mLatWdata;
   bit          mAck [2];
   bit          mErr [2];
   logic [31:0] mRdata [2];

   function automatic vec_t mkVec(
      input logic rs, input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
      input logic rdy, input logic [31:0] mrd,
      input logic eSt, input logic eA0, input logic eA1, input logic eE0, input logic eE1,
      input logic eMr, input logic eMv, input logic eMwe, input logic [31:0] eMa, input logic [31:0] eMwd,
      input logic [31:0] eR0, input logic [31:0] eR1);
      vec_t v;
      v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.rdy = rdy; v.mrd = mrd;
      v.eStall0 = eSt; v.eAck0 = eA0; v.eAck1 = eA1; v.eErr0 = eE0; v.eErr1 = eE1;
      v.eMemReq = eMr; v.eMemValid = eMv; v.eMemWe = eMwe; v.eMemAddr = eMa; v.eMemWdata = eMwd;
      v.eRd0 = eR0; v.eRd1 = eR1;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleAll();
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      memReady = 1'b0; memRdata = '0;
      req0T = 1'b0; we0T = 1'b0; addr0T = '0; wdata0T = '0;
      req1T = 1'b0; we1T = 1'b0; addr1T = '0; wdata1T = '0;
      memReadyT = 1'b0; memRdataT = '0;
   endtask

   task automatic doReset();
      idleAll();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      rst = v.rst;
      req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
      req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
      memReady = v.rdy; memRdata = v.mrd;
   endtask

   // Advance the reference model across one clock edge using the current inputs.
   task automatic modelStep();
      bit nAck [2];
      bit nErr [2];
      bit c0;
      bit c1;
      int g;
      nAck[0] = 1'b0; nAck[1] = 1'b0;
      nErr[0] = 1'b0; nErr[1] = 1'b0;
      if (rst) begin
         mOwner = -1; mAge = 0; mPrio = 0; mMemReq = 1'b0;
         mLatWe = 1'b0; mLatAddr = '0; mLatWdata = '0;
         mRdata[0] = '0; mRdata[1] = '0;
      end else if (mOwner < 0) begin
         c0 = req0 && !mAck[0] && !mErr[0];
         c1 = req1 && !mAck[1] && !mErr[1];
         g = -1;
         if (c0 && c1) g = mPrio;
         else if (c0) g = 0;
         else if (c1) g = 1;
         if (g == 0) begin
            mLatWe = we0; mLatAddr = addr0; mLatWdata = wdata0;
         end else if (g == 1) begin
            mLatWe = we1; mLatAddr = addr1; mLatWdata = wdata1;
         end
         if (g >= 0) begin
            mOwner = g; mAge = 0; mMemReq = 1'b1;
         end
      end else begin
         mAge++;
         if (memReady) begin
            if (!mLatWe) mRdata[mOwner] = memRdata;
            nAck[mOwner] = 1'b1;
            mPrio = 1 - mOwner;
            mOwner = -1;
            mMemReq = 1'b0;
         end else if (MAIN_TIMEOUT != 0 && mAge == MAIN_TIMEOUT) begin
            nErr[mOwner] = 1'b1;
            mPrio = 1 - mOwner;
            mOwner = -1;
            mMemReq = 1'b0;
         end
      end
      mAck = nAck;
      mErr = nErr;
   endtask

   task automatic compareModel(input int cyc);
      checkOutput($sformatf("rnd%0d.ack0", cyc), 32'(ack0), 32'(mAck[0]));
      checkOutput($sformatf("rnd%0d.ack1", cyc), 32'(ack1), 32'(mAck[1]));
      checkOutput($sformatf("rnd%0d.err0", cyc), 32'(err0), 32'(mErr[0]));
      checkOutput($sformatf("rnd%0d.err1", cyc), 32'(err1), 32'(mErr[1]));
      checkOutput($sformatf("rnd%0d.mem_req", cyc), 32'(memReq), 32'(mMemReq));
      checkOutput($sformatf("rnd%0d.rdata0", cyc), rdata0, mRdata[0]);
      checkOutput($sformatf("rnd%0d.rdata1", cyc), rdata1, mRdata[1]);
      if (mMemReq) begin
         checkOutput($sformatf("rnd%0d.mem_we", cyc), 32'(memWe), 32'(mLatWe));
         checkOutput($sformatf("rnd%0d.mem_addr", cyc), memAddr, mLatAddr);
         checkOutput($sformatf("rnd%0d.mem_wdata", cyc), memWdata, mLatWdata);
      end
   endtask

   function automatic bit nextReq(input bit cur, input bit done, input bit owned);
      if (!cur) return ($urandom_range(99) < 40);
      if (done) return ($urandom_range(99) < 30);
      if (owned) return ($urandom_range(99) >= 5);
      return 1'b1;
   endfunction

   initial begin
      int nAcks;
      compared = 0;
      mismatched = 0;
      idleAll();
      rst = 1'b0;

      // Directed cycles: reset, port-0 read, delayed port-1 write, ready while idle.
      //                    rst   r0    w0    a0      d0      r1    w1    a1      d1            rdy   mrd            st    a0    a1    e0    e1    mreq  mval  mwe   maddr   mwdata        rd0           rd1
      vecs[0]  = mkVec(1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,        32'h0,        32'h0);
      vecs[1]  = mkVec(1'b0, 1'b1, 1'b0, 32'h10, 32'h55, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h55,       32'h0,        32'h0);
      vecs[2]  = mkVec(1'b0, 1'b1, 1'b0, 32'h10, 32'h55, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h8C010004,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h8C010004, 32'h0);
      vecs[3]  = mkVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h8C010004, 32'h0);
      vecs[4]  = mkVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h8C010004, 32'h0);
      vecs[5]  = mkVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h7C, 32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h8C010004, 32'h0);
      vecs[6]  = mkVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h8C010004, 32'h0);
      vecs[7]  = mkVec(1'b0, 1'b1, 1'b1, 32'h99, 32'h77, 1'b1, 1'b0, 32'h84, 32'h1,        1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h8C010004, 32'h0);
      vecs[8]  = mkVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h88, 32'h2,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h8C010004, 32'h0);
      vecs[9]  = mkVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h8C, 32'h3,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h8C010004, 32'h0);
      vecs[10] = mkVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h7C, 32'h4,        1'b1, 32'h12345678,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h8C010004, 32'h0);
      vecs[11] = mkVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h8C010004, 32'h0);
      vecs[12] = mkVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h8C010004, 32'h0);

      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d.stall0", i), 32'(stall0), 32'(vecs[i].eStall0));
         tick();
         checkOutput($sformatf("vec%0d.ack0", i), 32'(ack0), 32'(vecs[i].eAck0));
         checkOutput($sformatf("vec%0d.ack1", i), 32'(ack1), 32'(vecs[i].eAck1));
         checkOutput($sformatf("vec%0d.err0", i), 32'(err0), 32'(vecs[i].eErr0));
         checkOutput($sformatf("vec%0d.err1", i), 32'(err1), 32'(vecs[i].eErr1));
         checkOutput($sformatf("vec%0d.mem_req", i), 32'(memReq), 32'(vecs[i].eMemReq));
         checkOutput($sformatf("vec%0d.rdata0", i), rdata0, vecs[i].eRd0);
         checkOutput($sformatf("vec%0d.rdata1", i), rdata1, vecs[i].eRd1);
         if (vecs[i].eMemValid) begin
            checkOutput($sformatf("vec%0d.mem_we", i), 32'(memWe), 32'(vecs[i].eMemWe));
            checkOutput($sformatf("vec%0d.mem_addr", i), memAddr, vecs[i].eMemAddr);
            checkOutput($sformatf("vec%0d.mem_wdata", i), memWdata, vecs[i].eMemWdata);
         end
      end

      // Continuous contention: both ports held, grants alternate starting with port 0.
      doReset();
      req0 = 1'b1; addr0 = 32'h100;
      req1 = 1'b1; addr1 = 32'h200;
      memReady = 1'b1; memRdata = 32'h0000_0ABC;
      nAcks = 0;
      for (int c = 0; c < 60 && nAcks < 6; c++) begin
         tick();
         if (ack0 || ack1) begin
            checkOutput($sformatf("order%0d.ack1", nAcks), 32'(ack1), 32'(nAcks % 2));
            nAcks++;
         end
      end
      checkOutput("order.count", nAcks, 32'd6);

      // Reset two cycles into a port-1 read; the held request is granted again afterwards.
      doReset();
      req1 = 1'b1; addr1 = 32'h84;
      tick();
      memReady = 1'b1; memRdata = 32'h600DCAFE;
      tick();
      checkOutput("rstBusy.prime.ack1", 32'(ack1), 32'd1);
      checkOutput("rstBusy.prime.rdata1", rdata1, 32'h600DCAFE);
      memReady = 1'b0; req1 = 1'b0;
      tick();
      req1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h5;
      tick();
      checkOutput("rstBusy.grant.mem_req", 32'(memReq), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("rstBusy.mem_req", 32'(memReq), 32'd0);
      checkOutput("rstBusy.mem_addr", memAddr, 32'h0);
      checkOutput("rstBusy.mem_wdata", memWdata, 32'h0);
      checkOutput("rstBusy.mem_we", 32'(memWe), 32'd0);
      checkOutput("rstBusy.ack1", 32'(ack1), 32'd0);
      checkOutput("rstBusy.err1", 32'(err1), 32'd0);
      checkOutput("rstBusy.rdata1", rdata1, 32'h0);
      rst = 1'b0;
      tick();
      checkOutput("rstBusy.regrant.mem_req", 32'(memReq), 32'd1);
      checkOutput("rstBusy.regrant.mem_addr", memAddr, 32'h80);
      memReady = 1'b1; memRdata = 32'h0F0F0F0F;
      tick();
      checkOutput("rstBusy.final.ack1", 32'(ack1), 32'd1);
      checkOutput("rstBusy.final.rdata1", rdata1, 32'h0F0F0F0F);
      memReady = 1'b0; req1 = 1'b0;

      // Port 0 holds its request through the ack: re-granted one cycle later.
      doReset();
      req0 = 1'b1; addr0 = 32'h20;
      tick();
      checkOutput("regrant.first.mem_req", 32'(memReq), 32'd1);
      memReady = 1'b1; memRdata = 32'h11112222;
      tick();
      checkOutput("regrant.ack0", 32'(ack0), 32'd1);
      checkOutput("regrant.rdata0", rdata0, 32'h11112222);
      memReady = 1'b0;
      tick();
      checkOutput("regrant.gap.mem_req", 32'(memReq), 32'd0);
      checkOutput("regrant.gap.ack0", 32'(ack0), 32'd0);
      tick();
      checkOutput("regrant.second.mem_req", 32'(memReq), 32'd1);
      checkOutput("regrant.second.mem_addr", memAddr, 32'h20);
      memReady = 1'b1;
      tick();
      checkOutput("regrant.second.ack0", 32'(ack0), 32'd1);
      req0 = 1'b0; memReady = 1'b0;

      // Watchdog with TIMEOUT=4: prime rdata0, then abort, then ready on the last cycle.
      doReset();
      req0T = 1'b1; addr0T = 32'h30;
      tick();
      memReadyT = 1'b1; memRdataT = 32'hA5A50001;
      tick();
      checkOutput("t4.prime.ack0", 32'(ack0T), 32'd1);
      checkOutput("t4.prime.rdata0", rdata0T, 32'hA5A50001);
      memReadyT = 1'b0; req0T = 1'b0;
      tick();
      req0T = 1'b1; addr0T = 32'h34;
      tick();
      for (int i = 1; i <= 4; i++) begin
         checkOutput($sformatf("t4.wait%0d.err0", i), 32'(err0T), 32'd0);
         checkOutput($sformatf("t4.wait%0d.mem_req", i), 32'(memReqT), 32'd1);
         tick();
      end
      checkOutput("t4.abort.err0", 32'(err0T), 32'd1);
      checkOutput("t4.abort.ack0", 32'(ack0T), 32'd0);
      checkOutput("t4.abort.mem_req", 32'(memReqT), 32'd0);
      checkOutput("t4.abort.rdata0", rdata0T, 32'hA5A50001);
      req0T = 1'b0;
      tick();
      checkOutput("t4.after.err0", 32'(err0T), 32'd0);
      req0T = 1'b1; addr0T = 32'h38;
      tick();
      tick();
      tick();
      tick();
      memReadyT = 1'b1; memRdataT = 32'h0BADF00D;
      tick();
      checkOutput("t4.edge.ack0", 32'(ack0T), 32'd1);
      checkOutput("t4.edge.err0", 32'(err0T), 32'd0);
      checkOutput("t4.edge.rdata0", rdata0T, 32'h0BADF00D);
      memReadyT = 1'b0; req0T = 1'b0;

      // Randomized traffic on both ports against the reference model.
      idleAll();
      rst = 1'b1;
      #1;
      modelStep();
      tick();
      rst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         compareModel(cyc);
         req0 = nextReq(req0, mAck[0] || mErr[0], mOwner == 0);
         req1 = nextReq(req1, mAck[1] || mErr[1], mOwner == 1);
         if ($urandom_range(99) < 30) begin
            we0 = 1'($urandom_range(1)); addr0 = $urandom; wdata0 = $urandom;
         end
         if ($urandom_range(99) < 30) begin
            we1 = 1'($urandom_range(1)); addr1 = $urandom; wdata1 = $urandom;
         end
         memReady = ($urandom_range(99) < 35);
         memRdata = $urandom;
         rst = ($urandom_range(999) < 4);
         #1;
         checkOutput($sformatf("rnd%0d.stall0", cyc), 32'(stall0), 32'(req0 & ~mAck[0] & ~mErr[0]));
         modelStep();
         tick();
      end
      compareModel(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
